alu_serial_rx: RTL and testbench

- Receive-side front end of the ALU serial protocol.
- Deserializes 10-bit words shifted MSB-first on din while enable_n is low.
- Buffers data (operand) words until a command word arrives, checks framing and parity, then presents one complete frame to the ALU core through a valid/ready handshake.
- Sits between the serial pins and the ALU datapath.

---
 rtl/alu_serial_rx.sv | 118 +++++++++++
 tb/tb_alu_serial_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_rx.sv
// Receive front end of the ALU serial link: deserializes 10-bit words, buffers
// operand payloads until a command word, and hands one checked frame to the core.
module alu_serial_rx #(
  parameter int WORD_W   = 10,
  parameter int MAX_DATA = 8,
  parameter int CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_n,
  input  logic                    din,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [8*MAX_DATA-1:0]   data_out,
  output logic [CNT_W-1:0]        data_count,
  output logic [7:0]              cmd_payload,
  output logic                    err_parity,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic                    err_abort
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state, state_next;
  logic [3:0]          bit_cnt;
  logic [WORD_W-2:0]   shift_q;
  logic [WORD_W-1:0]   word;
  logic [7:0]          data_mem [MAX_DATA];
  logic                word_done;
  logic                abort;
  logic                accept;

  // The 10th bit is still on din when the word completes, so it is appended here.
  assign word      = {shift_q, din};
  assign word_done = (state == SHIFT) && !enable_n && (bit_cnt == 4'(WORD_W - 1));
  assign abort     = (state == SHIFT) && enable_n;
  assign accept    = (state == HOLD) && frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!enable_n) state_next = SHIFT;
      SHIFT: begin
        if (abort)          state_next = HOLD;
        else if (word_done) state_next = word[WORD_W-1] ? HOLD : IDLE;
      end
      HOLD:  if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && !enable_n) begin
      shift_q <= {shift_q[WORD_W-3:0], din};
      bit_cnt <= 4'd1;
    end else if (state == SHIFT) begin
      if (enable_n) begin
        bit_cnt <= '0;
      end else begin
        shift_q <= {shift_q[WORD_W-3:0], din};
        bit_cnt <= word_done ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  // Frame contents and sticky error flags; everything is wiped when the core takes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_count    <= '0;
      cmd_payload   <= '0;
      err_parity    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_abort     <= 1'b0;
      for (int k = 0; k < MAX_DATA; k++) data_mem[k] <= '0;
    end else if (accept) begin
      data_count    <= '0;
      cmd_payload   <= '0;
      err_parity    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_abort     <= 1'b0;
      for (int k = 0; k < MAX_DATA; k++) data_mem[k] <= '0;
    end else if (abort) begin
      err_abort <= 1'b1;
    end else if (word_done) begin
      if (!(^word)) err_parity <= 1'b1;
      if (word[WORD_W-1]) begin
        cmd_payload <= word[WORD_W-2:1];
        if (data_count < CNT_W'(2)) err_underflow <= 1'b1;
      end else if (data_count < CNT_W'(MAX_DATA)) begin
        for (int k = 0; k < MAX_DATA; k++)
          if (data_count == CNT_W'(k)) data_mem[k] <= word[WORD_W-2:1];
        data_count <= data_count + CNT_W'(1);
      end else begin
        err_overflow <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_DATA; g++) begin : g_data_out
    assign data_out[8*g +: 8] = data_mem[g];
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed and randomized frames for alu_serial_rx, checked against a byte-queue
// model of the framing rules.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n, enable_n, din, frame_ready;
  logic        frame_valid;
  logic [63:0] data_out;
  logic [3:0]  data_count;
  logic [7:0]  cmd_payload;
  logic        err_parity, err_overflow, err_underflow, err_abort;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_data[$];
  logic [7:0] exp_cmd;
  bit         exp_par, exp_ovf, exp_und, exp_abort;

  alu_serial_rx dut (
    .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .din(din),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .data_out(data_out), .data_count(data_count), .cmd_payload(cmd_payload),
    .err_parity(err_parity), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] mkWord(bit is_cmd, logic [7:0] payload, bit good_par);
    logic [8:0] w9;
    w9 = {is_cmd, payload};
    return {w9, good_par ? ~(^w9) : (^w9)};
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    exp_data.delete();
    exp_cmd   = 8'h00;
    exp_par   = 1'b0;
    exp_ovf   = 1'b0;
    exp_und   = 1'b0;
    exp_abort = 1'b0;
  endtask

  // A completed word: odd total parity is good; commands close the frame.
  task automatic modelWord(logic [9:0] w);
    if ((^w) == 1'b0) exp_par = 1'b1;
    if (w[9]) begin
      exp_cmd = w[8:1];
      if (exp_data.size() < 2) exp_und = 1'b1;
    end else if (exp_data.size() < 8) begin
      exp_data.push_back(w[8:1]);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  function automatic logic [63:0] expDataOut();
    logic [63:0] r;
    r = '0;
    foreach (exp_data[i]) r[8*i +: 8] = exp_data[i];
    return r;
  endfunction

  task automatic checkFrame(string tag, bit exp_valid);
    checkOutput({tag, ".valid"}, 64'(frame_valid), 64'(exp_valid));
    checkOutput({tag, ".count"}, 64'(data_count), 64'(exp_data.size()));
    checkOutput({tag, ".data"}, data_out, expDataOut());
    checkOutput({tag, ".cmd"}, 64'(cmd_payload), 64'(exp_cmd));
    checkOutput({tag, ".errs"}, 64'({err_parity, err_overflow, err_underflow, err_abort}),
                64'({exp_par, exp_ovf, exp_und, exp_abort}));
  endtask

  task automatic applyStimulus(logic [9:0] w, int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      enable_n = 1'b0;
      din      = w[9-i];
    end
  endtask

  task automatic idleCycles(int n);
    repeat (n) begin
      @(negedge clk);
      enable_n = 1'b1;
      din      = 1'($urandom);
    end
  endtask

  task automatic sendWord(logic [9:0] w);
    applyStimulus(w, 10);
    modelWord(w);
  endtask

  // After the last command bit is driven: not valid yet, valid one cycle later.
  task automatic finishCommand(string tag);
    checkOutput({tag, ".pre_valid"}, 64'(frame_valid), 64'(0));
    @(negedge clk);
    enable_n = 1'b1;
    din      = 1'b0;
    checkFrame(tag, 1'b1);
  endtask

  task automatic acceptFrame(string tag);
    frame_ready = 1'b1;
    enable_n    = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    modelReset();
    checkFrame({tag, ".cleared"}, 1'b0);
  endtask

  initial begin
    logic [9:0] w;
    int nd, k, hold_wait;

    rst_n = 1'b0; enable_n = 1'b1; din = 1'b0; frame_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkFrame("reset", 1'b0);
    rst_n = 1'b1;
    idleCycles(2);

    // Nominal frame with frame_ready held high throughout
    frame_ready = 1'b1;
    sendWord(10'h025);
    sendWord(10'h068);
    sendWord(10'h203);
    finishCommand("nominal");
    checkOutput("nominal.slot0", 64'(data_out[7:0]), 64'h12);
    checkOutput("nominal.slot1", 64'(data_out[15:8]), 64'h34);
    @(negedge clk);
    modelReset();
    checkFrame("nominal.after", 1'b0);
    frame_ready = 1'b0;
    idleCycles(2);

    // Backpressure: sender chatter during HOLD must be ignored
    sendWord(10'h025);
    sendWord(10'h068);
    sendWord(10'h203);
    finishCommand("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable_n = 1'($urandom);
      din      = 1'($urandom);
      checkFrame("bp.hold", 1'b1);
    end
    acceptFrame("bp");
    idleCycles(2);

    // Bad parity on a lone data word, then command
    sendWord(10'h024);
    sendWord(10'h203);
    finishCommand("par_und");
    checkOutput("par_und.flags", 64'({err_parity, err_underflow}), 64'b11);
    acceptFrame("par_und");

    // Nine data words back to back
    repeat (9) sendWord(10'h025);
    sendWord(10'h203);
    finishCommand("ovf");
    checkOutput("ovf.slots", data_out, {8{8'h12}});
    acceptFrame("ovf");
    idleCycles(1);

    // Abort after 4 bits of the second word
    sendWord(10'h025);
    applyStimulus(10'h068, 4);
    @(negedge clk);
    enable_n = 1'b1;
    checkOutput("abort.pre_valid", 64'(frame_valid), 64'(0));
    exp_abort = 1'b1;
    @(negedge clk);
    checkFrame("abort", 1'b1);
    acceptFrame("abort");
    idleCycles(1);

    // Asynchronous reset between clock edges, mid-word
    sendWord(10'h025);
    applyStimulus(10'h068, 6);
    @(posedge clk);
    #2;
    checkOutput("areset.before", 64'(data_count), 64'(1));
    rst_n = 1'b0;
    #1;
    modelReset();
    checkFrame("areset", 1'b0);
    @(negedge clk);
    enable_n = 1'b1;
    rst_n    = 1'b1;
    idleCycles(1);
    sendWord(10'h025);
    sendWord(10'h068);
    sendWord(10'h203);
    finishCommand("areset.nominal");
    acceptFrame("areset.nominal");

    // Randomized frames: varied length, gaps, parity faults, aborts, backpressure
    for (int f = 0; f < 25; f++) begin
      nd = $urandom_range(0, 10);
      for (int j = 0; j < nd; j++) begin
        idleCycles(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        w = mkWord(1'b0, 8'($urandom), $urandom_range(0, 7) != 0);
        sendWord(w);
      end
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(1, 9);
        applyStimulus(10'($urandom), k);
        @(negedge clk);
        enable_n = 1'b1;
        exp_abort = 1'b1;
        @(negedge clk);
        checkFrame("rand.abort", 1'b1);
      end else begin
        w = mkWord(1'b1, 8'($urandom), $urandom_range(0, 7) != 0);
        sendWord(w);
        finishCommand("rand.cmd");
      end
      hold_wait = $urandom_range(0, 3);
      repeat (hold_wait) begin
        @(negedge clk);
        enable_n = 1'($urandom);
        din      = 1'($urandom);
        checkFrame("rand.hold", 1'b1);
      end
      acceptFrame("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
